// File: rtl/ui_cfg_pkg.sv
// Shared types for the button-driven LED configuration controller:
// per-button FSM state, the event bundle each button FSM emits, and brightness stepping.
package ui_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DOWN = 2'd1,
      LONG = 2'd2
   } btn_state_t;

   typedef struct packed {
      logic press;
      logic short_press;
      logic long_press;
      logic repeat_press;
   } btn_evt_t;

   // Saturating brightness step in either direction.
   function automatic logic [7:0] step_bright(input logic [7:0] b, input logic [7:0] step, input logic up);
      logic [8:0] sum;
      sum = {1'b0, b} + {1'b0, step};
      if (up) begin
         step_bright = sum[8] ? 8'hFF : sum[7:0];
      end else begin
         step_bright = (b < step) ? 8'h00 : (b - step);
      end
   endfunction

endpackage

// File: rtl/btn_fsm.sv
// Per-button press classifier: press, short, long and auto-repeat pulses, all registered.
// A button held through reset stays disarmed until it has been seen released.
module btn_fsm
   import ui_cfg_pkg::*;
#(
   parameter int LONG_MS   = 500,
   parameter int REPEAT_MS = 100
) (
   input  logic     clock,
   input  logic     reset,
   input  logic     tick,
   input  logic     btn,
   output btn_evt_t evt
);

   localparam int CMAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_MS - 1);
   localparam logic [CW-1:0] CNT_SAT   = {CW{1'b1}};

   btn_state_t    state_q, state_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   btn_evt_t      evt_q, evt_d;

   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + CW'(1));
   assign evt     = evt_q;

   always_comb begin
      state_d = state_q;
      armed_d = armed_q | ~btn;
      cnt_d   = cnt_q;
      evt_d   = '0;
      case (state_q)
         IDLE: begin
            if (armed_q && btn) begin
               state_d     = DOWN;
               evt_d.press = 1'b1;
               cnt_d       = '0;
            end
         end
         DOWN: begin
            if (!btn) begin
               state_d           = IDLE;
               evt_d.short_press = 1'b1;
            end else if (tick) begin
               if (cnt_q == LONG_LAST) begin
                  state_d          = LONG;
                  evt_d.long_press = 1'b1;
                  cnt_d            = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         LONG: begin
            // Release from a long hold is silent.
            if (!btn) begin
               state_d = IDLE;
            end else if (tick) begin
               if (cnt_q == REP_LAST) begin
                  evt_d.repeat_press = 1'b1;
                  cnt_d              = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         armed_q <= 1'b0;
         cnt_q   <= '0;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
         evt_q   <= evt_d;
      end
   end

endmodule

// File: rtl/ui_config_ctrl.sv
// Button UI to LED-engine configuration: tick prescaler, three button FSMs,
// shadow mode/brightness with dirty flag, and a valid/ready output register.
module ui_config_ctrl
   import ui_cfg_pkg::*;
#(
   parameter int TICK_DIV       = 50000,
   parameter int LONG_MS        = 500,
   parameter int REPEAT_MS      = 100,
   parameter int NUM_MODES      = 8,
   parameter int BRIGHT_STEP    = 16,
   parameter int BRIGHT_DEFAULT = 128
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         btn_mode,
   input  logic                         btn_up,
   input  logic                         btn_down,
   output logic [$clog2(NUM_MODES)-1:0] mode,
   output logic [7:0]                   brightness,
   output logic                         cfg_valid,
   input  logic                         cfg_ready
);

   localparam int MW = $clog2(NUM_MODES);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);
   localparam logic [7:0]    B_DEF     = 8'(BRIGHT_DEFAULT);
   localparam logic [7:0]    B_STEP    = 8'(BRIGHT_STEP);

   logic [TW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;
   btn_evt_t      evt_mode, evt_up, evt_down;
   logic [MW-1:0] sh_mode_q, sh_mode_d, mode_q, mode_d;
   logic [7:0]    sh_bright_q, sh_bright_d, bright_q, bright_d;
   logic          dirty_q, dirty_d, valid_q, valid_d;
   logic          up_step, dn_step, changed, load;
   logic          evt_unused;

   btn_fsm #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_mode (
      .clock(clock), .reset(reset), .tick(tick_q), .btn(btn_mode), .evt(evt_mode));
   btn_fsm #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_up (
      .clock(clock), .reset(reset), .tick(tick_q), .btn(btn_up), .evt(evt_up));
   btn_fsm #(.LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS)) u_down (
      .clock(clock), .reset(reset), .tick(tick_q), .btn(btn_down), .evt(evt_down));

   // Mode reacts only to short/long; brightness ignores short release.
   assign evt_unused = evt_mode.press | evt_mode.repeat_press | evt_up.short_press | evt_down.short_press;
   assign up_step    = evt_up.press | evt_up.long_press | evt_up.repeat_press;
   assign dn_step    = evt_down.press | evt_down.long_press | evt_down.repeat_press;

   assign mode       = mode_q;
   assign brightness = bright_q;
   assign cfg_valid  = valid_q;

   always_comb begin
      presc_d     = (presc_q == TICK_LAST) ? '0 : (presc_q + TW'(1));
      tick_d      = (presc_q == TICK_LAST);
      sh_mode_d   = sh_mode_q;
      sh_bright_d = sh_bright_q;
      if (evt_mode.long_press) begin
         sh_mode_d   = '0;
         sh_bright_d = B_DEF;
      end else begin
         if (evt_mode.short_press) begin
            sh_mode_d = (sh_mode_q == MODE_LAST) ? '0 : (sh_mode_q + MW'(1));
         end else begin
            sh_mode_d = sh_mode_q;
         end
         if (up_step && !dn_step) begin
            sh_bright_d = step_bright(sh_bright_q, B_STEP, 1'b1);
         end else if (dn_step && !up_step) begin
            sh_bright_d = step_bright(sh_bright_q, B_STEP, 1'b0);
         end else begin
            sh_bright_d = sh_bright_q;
         end
      end
      // Saturated no-ops leave the shadow untouched and so raise nothing.
      changed = (sh_mode_d != sh_mode_q) || (sh_bright_d != sh_bright_q);
      load    = !valid_q && dirty_q;
      dirty_d = (dirty_q && !load) || changed;
      mode_d  = mode_q;
      bright_d = bright_q;
      valid_d = valid_q;
      if (load) begin
         mode_d   = sh_mode_q;
         bright_d = sh_bright_q;
         valid_d  = 1'b1;
      end else if (valid_q && cfg_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc_q     <= '0;
         tick_q      <= 1'b0;
         sh_mode_q   <= '0;
         sh_bright_q <= B_DEF;
         dirty_q     <= 1'b0;
         mode_q      <= '0;
         bright_q    <= B_DEF;
         valid_q     <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         tick_q      <= tick_d;
         sh_mode_q   <= sh_mode_d;
         sh_bright_q <= sh_bright_d;
         dirty_q     <= dirty_d;
         mode_q      <= mode_d;
         bright_q    <= bright_d;
         valid_q     <= valid_d;
      end
   end

endmodule

// File: tb/tb_ui_config_ctrl.sv
// Bench for ui_config_ctrl: directed vector table, randomized holds against a
// transaction-level model, and hand sequences for reset and pending-transfer cases.
module tb_ui_config_ctrl;

   localparam int TD = 4, LM = 10, RM = 3, NM = 8, STEP = 16, DEF = 128;

   logic       clock = 1'b0, reset = 1'b1;
   logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, cfg_ready = 1'b0;
   logic [2:0] mode;
   logic [7:0] brightness;
   logic       cfg_valid;

   int pass_cnt = 0, chk_cnt = 0;
   int m_mode = 0, m_bright = DEF;
   int exp_q[$];
   bit mon_en = 1'b0;

   typedef struct {
      int btn;
      int hold;
      int exp_mode;
      int exp_bright;
   } vec_t;
   vec_t vecs[20];

   ui_config_ctrl #(
      .TICK_DIV(TD), .LONG_MS(LM), .REPEAT_MS(RM),
      .NUM_MODES(NM), .BRIGHT_STEP(STEP), .BRIGHT_DEFAULT(DEF)
   ) dut (
      .clock(clock), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
      .mode(mode), .brightness(brightness), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_mode = v;
         1: btn_up = v;
         default: btn_down = v;
      endcase
   endtask

   function automatic int clamp_b(input int v);
      return (v > 255) ? 255 : ((v < 0) ? 0 : v);
   endfunction

   // Model: a hold of h ticks yields press, then long at LM and repeats every RM.
   task automatic m_apply(input int b, input int h);
      int n;
      if (b == 0) begin
         if (h < LM) begin
            m_mode = (m_mode + 1) % NM;
            exp_q.push_back(m_mode * 256 + m_bright);
         end else if (m_mode != 0 || m_bright != DEF) begin
            m_mode = 0;
            m_bright = DEF;
            exp_q.push_back(m_mode * 256 + m_bright);
         end
      end else begin
         n = 1 + ((h >= LM) ? (1 + (h - LM) / RM) : 0);
         repeat (n) begin
            int nb;
            nb = clamp_b(m_bright + ((b == 1) ? STEP : -STEP));
            if (nb != m_bright) begin
               m_bright = nb;
               exp_q.push_back(m_mode * 256 + m_bright);
            end
         end
      end
   endtask

   // TD*h+1 cycles of press gives exactly h ticks seen while held.
   task automatic hold(input int b, input int h);
      m_apply(b, h);
      set_btn(b, 1'b1);
      cycles(TD * h + 1);
      set_btn(b, 1'b0);
      cycles(8);
   endtask

   always @(negedge clock) begin
      if (mon_en && cfg_valid && cfg_ready) begin
         if (exp_q.size() == 0) check("xfer_unexpected", int'(mode) * 256 + int'(brightness), -1);
         else check("xfer", int'(mode) * 256 + int'(brightness), exp_q.pop_front());
      end
   end

   initial begin
      int vcnt, start;
      vecs[0]  = '{0, 5, 1, 128};
      vecs[1]  = '{1, 20, 1, 208};
      vecs[2]  = '{1, 2, 1, 224};
      vecs[3]  = '{1, 1, 1, 240};
      vecs[4]  = '{1, 1, 1, 255};
      vecs[5]  = '{1, 1, 1, 255};
      vecs[6]  = '{2, 12, 1, 223};
      vecs[7]  = '{0, 3, 2, 223};
      vecs[8]  = '{0, 10, 0, 128};
      vecs[9]  = '{2, 25, 0, 16};
      vecs[10] = '{2, 3, 0, 0};
      vecs[11] = '{2, 1, 0, 0};
      for (int k = 1; k <= 7; k++) vecs[11 + k] = '{0, 2, k, 0};
      vecs[19] = '{0, 2, 0, 0};

      cycles(2);
      check("reset_mode", int'(mode), 0);
      check("reset_bright", int'(brightness), DEF);
      check("reset_valid", int'(cfg_valid), 0);
      reset = 1'b0;
      cycles(3);
      cfg_ready = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < 20; i++) begin
         hold(vecs[i].btn, vecs[i].hold);
         check($sformatf("vec%0d_mode", i), int'(mode), vecs[i].exp_mode);
         check($sformatf("vec%0d_bright", i), int'(brightness), vecs[i].exp_bright);
         check($sformatf("vec%0d_valid", i), int'(cfg_valid), 0);
      end

      for (int i = 0; i < 25; i++) begin
         hold(int'($urandom_range(0, 2)), int'($urandom_range(1, 24)));
         cycles(int'($urandom_range(0, 5)));
         check($sformatf("rand%0d_mode", i), int'(mode), m_mode);
         check($sformatf("rand%0d_bright", i), int'(brightness), m_bright);
      end
      hold(0, 11);
      check("queue_drained", exp_q.size(), 0);
      mon_en = 1'b0;

      // Up and down pressed together cancel.
      vcnt = 0;
      btn_up = 1'b1;
      btn_down = 1'b1;
      repeat (TD * 3) begin cycles(1); vcnt += int'(cfg_valid); end
      btn_up = 1'b0;
      btn_down = 1'b0;
      repeat (6) begin cycles(1); vcnt += int'(cfg_valid); end
      check("updown_valid_cycles", vcnt, 0);
      check("updown_bright", int'(brightness), 128);

      // Events accumulate while a transfer is pending.
      cfg_ready = 1'b0;
      start = m_mode;
      repeat (3) begin
         btn_mode = 1'b1;
         cycles(TD * 2 + 1);
         btn_mode = 1'b0;
         cycles(4);
      end
      check("pend_mode_frozen", int'(mode), (start + 1) % NM);
      check("pend_valid", int'(cfg_valid), 1);
      cfg_ready = 1'b1;
      cycles(1);
      cfg_ready = 1'b0;
      check("accept_valid_drop", int'(cfg_valid), 0);
      cycles(1);
      check("second_xfer_mode", int'(mode), (start + 3) % NM);
      check("second_xfer_valid", int'(cfg_valid), 1);
      cfg_ready = 1'b1;
      cycles(2);
      check("second_xfer_done", int'(cfg_valid), 0);

      // Asynchronous reset while a transfer is pending.
      cfg_ready = 1'b0;
      btn_up = 1'b1;
      cycles(TD * 2 + 1);
      btn_up = 1'b0;
      cycles(5);
      check("pre_reset_bright", int'(brightness), 144);
      check("pre_reset_valid", int'(cfg_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_mode", int'(mode), 0);
      check("async_reset_bright", int'(brightness), DEF);
      check("async_reset_valid", int'(cfg_valid), 0);

      // Button held across reset release stays silent until released.
      btn_up = 1'b1;
      cycles(2);
      reset = 1'b0;
      vcnt = 0;
      repeat (TD * 20) begin cycles(1); vcnt += int'(cfg_valid); end
      check("held_reset_valid_cycles", vcnt, 0);
      check("held_reset_bright", int'(brightness), DEF);
      btn_up = 1'b0;
      cycles(4);
      m_mode = 0;
      m_bright = DEF;
      exp_q.delete();
      cfg_ready = 1'b1;
      mon_en = 1'b1;
      hold(1, 2);
      check("post_reset_bright", int'(brightness), 144);
      check("final_queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
